// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: accepts a sample, sweeps LENGTH taps through delay line/coef/MAC, drains MAC_LAT, holds result.
// Latency: out_valid LENGTH+MAC_LAT+1 cycles after accept; backpressure holds DONE until out_ready.
module fir_tap_sequencer #(
  parameter int LENGTH  = 64,
  parameter int ADDR_W  = 6,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sr_shift,
  output logic [ADDR_W-1:0] sr_address,
  output logic [ADDR_W-1:0] coef_address,
  output logic              mac_clear,
  output logic              mac_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  if (LENGTH < 2 || LENGTH > 2**ADDR_W || MAC_LAT < 0 || MAC_LAT > 15) begin : g_param_check
    $error("fir_tap_sequencer: illegal LENGTH/ADDR_W/MAC_LAT combination");
  end

  typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} state_e;

  // Compare against the last tap rather than counting past it, so LENGTH == 2**ADDR_W never wraps.
  localparam logic [ADDR_W-1:0] LAST_TAP   = ADDR_W'(LENGTH - 1);
  localparam logic [3:0]        DRAIN_INIT = 4'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tap_q, tap_d;
  logic [3:0]        drain_q, drain_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tap_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    drain_d      = drain_q;
    in_ready     = 1'b0;
    mac_en       = 1'b0;
    mac_clear    = 1'b0;
    out_valid    = 1'b0;
    sr_address   = '0;
    coef_address = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = CALC;
          tap_d   = '0;
        end
      end
      CALC: begin
        mac_en       = 1'b1;
        sr_address   = tap_q;
        coef_address = tap_q;
        mac_clear    = (tap_q == '0);
        if (tap_q == LAST_TAP) begin
          tap_d = '0;
          if (MAC_LAT == 0) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
            drain_d = DRAIN_INIT;
          end
        end else begin
          tap_d = tap_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == 4'd0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Handshake with a waiting sample restarts the sweep with no idle bubble.
        if (out_ready) begin
          if (in_valid) begin
            state_d = CALC;
            tap_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sr_shift = in_valid & in_ready;
  assign busy     = (state_q != IDLE);

endmodule
